// File: rtl/btn_pkg.sv
// Shared state encoding and 27 MHz timing defaults for the push-button conditioner.
package btn_pkg;

  typedef enum logic [1:0] {
    REL = 2'd0,
    ARM = 2'd1,
    PRS = 2'd2,
    DIS = 2'd3
  } btn_state_e;

  localparam int unsigned DEF_DEB_CYCLES  = 270000;
  localparam int unsigned DEF_LONG_CYCLES = 27000000;

  // Counter width for a terminal count of n-1, never narrower than one bit.
  function automatic int unsigned cntWidth(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/btn_debounce_ch.sv
// One button channel: 2-FF synchroniser, debounce FSM, strobes and press toggle.
// Optional long-press strobe is built only when BTN_LONG_PRESS_EN is defined.
module btn_debounce_ch
  import btn_pkg::*;
#(
  parameter int unsigned DEB_CYCLES  = DEF_DEB_CYCLES,
  parameter bit          ACTIVE_LOW  = 1'b1,
  parameter bit          TOGGLE_INIT = 1'b1,
  parameter int unsigned LONG_CYCLES = DEF_LONG_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw_i,
  output logic pressed_o,
  output logic press_p_o,
  output logic release_p_o,
  output logic toggle_o,
  output logic long_p_o
);

  localparam int unsigned      CNT_W   = cntWidth(DEB_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEB_CYCLES - 1);

  logic             sync1_q;
  logic             sync2_q;
  logic             lvl;
  btn_state_e       state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             pressAccept;
  logic             releaseAccept;

  assign lvl           = sync2_q ^ ACTIVE_LOW;
  assign pressAccept   = (state_q == ARM) && lvl && (cnt_q == CNT_MAX);
  assign releaseAccept = (state_q == DIS) && !lvl && (cnt_q == CNT_MAX);

  // Leaving REL/PRS already counts as the first stable cycle, hence cnt starts at 1.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q     <= ACTIVE_LOW;
      sync2_q     <= ACTIVE_LOW;
      state_q     <= REL;
      cnt_q       <= '0;
      pressed_o   <= 1'b0;
      press_p_o   <= 1'b0;
      release_p_o <= 1'b0;
      toggle_o    <= TOGGLE_INIT;
    end else begin
      sync1_q     <= btn_raw_i;
      sync2_q     <= sync1_q;
      press_p_o   <= 1'b0;
      release_p_o <= 1'b0;
      case (state_q)
        REL: begin
          cnt_q <= '0;
          if (lvl) begin
            state_q <= ARM;
            cnt_q   <= CNT_W'(1);
          end
        end
        ARM: begin
          if (!lvl) begin
            state_q <= REL;
            cnt_q   <= '0;
          end else if (pressAccept) begin
            state_q   <= PRS;
            cnt_q     <= '0;
            pressed_o <= 1'b1;
            press_p_o <= 1'b1;
            toggle_o  <= ~toggle_o;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        PRS: begin
          cnt_q <= '0;
          if (!lvl) begin
            state_q <= DIS;
            cnt_q   <= CNT_W'(1);
          end
        end
        DIS: begin
          if (lvl) begin
            state_q <= PRS;
            cnt_q   <= '0;
          end else if (releaseAccept) begin
            state_q     <= REL;
            cnt_q       <= '0;
            pressed_o   <= 1'b0;
            release_p_o <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_q <= REL;
          cnt_q   <= '0;
        end
      endcase
    end
  end

`ifdef BTN_LONG_PRESS_EN
  localparam int unsigned       HOLD_W   = cntWidth(LONG_CYCLES);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(LONG_CYCLES - 1);

  logic [HOLD_W-1:0] hold_q;
  logic [HOLD_W-1:0] hold_d;
  logic              long_d;

  // Hold counter saturates at its terminal value so the strobe fires once per press.
  always_comb begin
    hold_d = hold_q;
    long_d = 1'b0;
    if (pressAccept) begin
      hold_d = '0;
    end else if ((state_q == PRS || state_q == DIS) && hold_q != HOLD_MAX) begin
      hold_d = hold_q + HOLD_W'(1);
      long_d = (hold_d == HOLD_MAX);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_q   <= '0;
      long_p_o <= 1'b0;
    end else begin
      hold_q   <= hold_d;
      long_p_o <= long_d;
    end
  end
`else
  assign long_p_o = 1'b0;
`endif

endmodule

// File: rtl/btn_debounce.sv
// Push-button conditioner: N_BTN independent debounce channels feeding the LED counter.
// Define BTN_LONG_PRESS_EN to enable the long-press strobe on long_p.
module btn_debounce
  import btn_pkg::*;
#(
  parameter int unsigned N_BTN       = 2,
  parameter int unsigned DEB_CYCLES  = DEF_DEB_CYCLES,
  parameter bit          ACTIVE_LOW  = 1'b1,
  parameter bit          TOGGLE_INIT = 1'b1,
  parameter int unsigned LONG_CYCLES = DEF_LONG_CYCLES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] pressed,
  output logic [N_BTN-1:0] press_p,
  output logic [N_BTN-1:0] release_p,
  output logic [N_BTN-1:0] toggle_q,
  output logic [N_BTN-1:0] long_p
);

  for (genvar g = 0; g < N_BTN; g++) begin : gen_ch
    btn_debounce_ch #(
      .DEB_CYCLES (DEB_CYCLES),
      .ACTIVE_LOW (ACTIVE_LOW),
      .TOGGLE_INIT(TOGGLE_INIT),
      .LONG_CYCLES(LONG_CYCLES)
    ) u_ch (
      .clk        (clk),
      .rst        (rst),
      .btn_raw_i  (btn_raw[g]),
      .pressed_o  (pressed[g]),
      .press_p_o  (press_p[g]),
      .release_p_o(release_p[g]),
      .toggle_o   (toggle_q[g]),
      .long_p_o   (long_p[g])
    );
  end

endmodule
